// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU port: FSM encoding, port selects and status bit layout.
package vdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_PF   = 2'd2
    } vdp_state_e;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    localparam int STAT_F  = 7;
    localparam int STAT_5S = 6;
    localparam int STAT_C  = 5;

    // Reported in the low status bits while no fifth-sprite event is latched.
    localparam logic [4:0] FIFTH_NONE = 5'h1F;

endpackage

// File: rtl/vdp_status.sv
// Sticky frame-interrupt, collision and fifth-sprite flags with fifth-number latch.
module vdp_status
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       int_set,
    input  logic       coll_set,
    input  logic       fifth_set,
    input  logic [4:0] fifth_num,
    input  logic       clr,
    output logic [7:0] status,
    output logic       f_flag
);

    logic       c_flag;
    logic       s5_flag;
    logic [4:0] num_q;

    // Set pulses are applied after the clear so a coincident event is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_flag  <= 1'b0;
            c_flag  <= 1'b0;
            s5_flag <= 1'b0;
            num_q   <= 5'd0;
        end else begin
            if (clr) begin
                f_flag  <= 1'b0;
                c_flag  <= 1'b0;
                s5_flag <= 1'b0;
            end
            if (int_set)  f_flag <= 1'b1;
            if (coll_set) c_flag <= 1'b1;
            if (fifth_set) begin
                s5_flag <= 1'b1;
                num_q   <= fifth_num;
            end
        end
    end

    always_comb begin
        status          = 8'h00;
        status[STAT_F]  = f_flag;
        status[STAT_5S] = s5_flag;
        status[STAT_C]  = c_flag;
        status[4:0]     = s5_flag ? num_q : FIFTH_NONE;
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: control/data port decode, register file, VRAM request FSM with one pending slot.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_ce,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic              mode_ctrl,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_re,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic [63:0]       regs,
    input  logic              int_set,
    input  logic              coll_set,
    input  logic              fifth_set,
    input  logic [4:0]        fifth_num,
    output logic              n_int,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        fsm_state
);

    vdp_state_e        state;
    vdp_state_e        pend_op;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_wdata;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_buf;
    logic [7:0]        first_byte;
    logic              latch;
    logic              prev_wr, prev_rd, rd_port;
    logic [7:0]        status;
    logic              f_flag;

    // Accesses act on the cpu_ce where the strobe level first differs from the previous cpu_ce.
    logic wr_start, rd_start, rd_end, stat_clr;
    assign wr_start = cpu_ce & io_wr & ~prev_wr;
    assign rd_start = cpu_ce & io_rd & ~prev_rd;
    assign rd_end   = cpu_ce & ~io_rd & prev_rd;
    assign stat_clr = rd_end & (rd_port == PORT_CTRL);

    logic [13:0]       ctrl_full;
    logic [ADDR_W-1:0] ctrl_addr;
    assign ctrl_full = {cpu_din[5:0], first_byte};
    assign ctrl_addr = ADDR_W'(ctrl_full);

    logic              req_valid, addr_load, addr_inc, data_wr;
    vdp_state_e        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;

    always_comb begin
        req_valid = 1'b0;
        req_op    = ST_IDLE;
        req_addr  = '0;
        req_wdata = 8'h00;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        data_wr   = 1'b0;
        if (wr_start && mode_ctrl == PORT_CTRL) begin
            if (latch && !cpu_din[7]) begin
                addr_load = 1'b1;
                if (!cpu_din[6]) begin
                    req_valid = 1'b1;
                    req_op    = ST_PF;
                    req_addr  = ctrl_addr;
                end
            end
        end else if (wr_start) begin
            req_valid = 1'b1;
            req_op    = ST_WR;
            req_addr  = addr;
            req_wdata = cpu_din;
            addr_inc  = 1'b1;
            data_wr   = 1'b1;
        end else if (rd_end && rd_port == PORT_DATA) begin
            req_valid = 1'b1;
            req_op    = ST_PF;
            req_addr  = addr + ADDR_W'(1);
            addr_inc  = 1'b1;
        end
    end

    // The pending slot frees on the same IDLE cycle it issues, so it can accept a new entry then.
    logic idle, direct, to_pend, drop;
    assign idle    = (state == ST_IDLE);
    assign direct  = req_valid & idle & ~pend_valid;
    assign to_pend = req_valid & ~direct & (~pend_valid | idle);
    assign drop    = req_valid & ~direct & ~to_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
            pend_op    <= ST_IDLE;
            pend_addr  <= '0;
            pend_wdata <= 8'h00;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
            addr       <= '0;
            rd_buf     <= 8'h00;
            first_byte <= 8'h00;
            latch      <= 1'b0;
            regs       <= 64'd0;
            prev_wr    <= 1'b0;
            prev_rd    <= 1'b0;
            rd_port    <= PORT_DATA;
            overrun    <= 1'b0;
            cpu_dout   <= FIFTH_NONE;
        end else begin
            if (cpu_ce) begin
                prev_wr <= io_wr;
                prev_rd <= io_rd;
            end
            if (rd_start) rd_port <= mode_ctrl;

            if (wr_start && mode_ctrl == PORT_CTRL) begin
                if (!latch) begin
                    first_byte <= cpu_din;
                    latch      <= 1'b1;
                end else begin
                    latch <= 1'b0;
                    if (cpu_din[7]) regs[{cpu_din[2:0], 3'b000} +: 8] <= first_byte;
                end
            end else if (wr_start || rd_start) begin
                latch <= 1'b0;
            end

            if (addr_load)             addr <= ctrl_addr;
            else if (addr_inc && !drop) addr <= addr + ADDR_W'(1);

            case (state)
                ST_WR, ST_PF: begin
                    if (vram_ack) begin
                        if (state == ST_PF) rd_buf <= vram_rdata;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (pend_valid) begin
                        state      <= pend_op;
                        vram_addr  <= pend_addr;
                        vram_wdata <= pend_wdata;
                        pend_valid <= 1'b0;
                    end else if (direct) begin
                        state      <= req_op;
                        vram_addr  <= req_addr;
                        vram_wdata <= req_wdata;
                    end
                end
            endcase

            if (to_pend) begin
                pend_valid <= 1'b1;
                pend_op    <= req_op;
                pend_addr  <= req_addr;
                pend_wdata <= req_wdata;
            end

            // A CPU write is newer than any prefetch completing in the same cycle.
            if (data_wr && !drop) rd_buf <= cpu_din;

            overrun  <= drop;
            cpu_dout <= (mode_ctrl == PORT_CTRL) ? status : rd_buf;
        end
    end

    assign vram_we   = (state == ST_WR);
    assign vram_re   = (state == ST_PF);
    assign busy      = ~idle | pend_valid;
    assign n_int     = ~(f_flag & regs[13]);
    assign fsm_state = state;

    vdp_status u_status (
        .clk       (clk),
        .reset_n   (reset_n),
        .int_set   (int_set),
        .coll_set  (coll_set),
        .fifth_set (fifth_set),
        .fifth_num (fifth_num),
        .clr       (stat_clr),
        .status    (status),
        .f_flag    (f_flag)
    );

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: port decode, VRAM requests, pending/overrun, status flags, reset.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b1;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic        mode_ctrl = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we, vram_re;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic [63:0] regs;
    logic        int_set = 1'b0, coll_set = 1'b0, fifth_set = 1'b0;
    logic [4:0]  fifth_num = 5'd0;
    logic        n_int, busy, overrun;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;
    logic ovr_seen;

    vdp_cpu_port #(.ADDR_W(14)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_ce     (cpu_ce),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .mode_ctrl  (mode_ctrl),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_re    (vram_re),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .regs       (regs),
        .int_set    (int_set),
        .coll_set   (coll_set),
        .fifth_set  (fifth_set),
        .fifth_num  (fifth_num),
        .n_int      (n_int),
        .busy       (busy),
        .overrun    (overrun),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic port, input logic [7:0] data);
        mode_ctrl = port;
        cpu_din   = data;
        io_wr     = 1'b1;
        tick();
        ovr_seen = overrun;
        io_wr = 1'b0;
        tick();
    endtask

    task automatic cpu_read_start(input logic port);
        mode_ctrl = port;
        io_rd     = 1'b1;
        tick();
        tick();
    endtask

    task automatic cpu_read_end();
        io_rd = 1'b0;
        tick();
    endtask

    task automatic do_ack(input logic [7:0] rdata);
        int n = 0;
        while (!(vram_we || vram_re) && n < 20) begin
            tick();
            n++;
        end
        check("ack_wait_request", {63'd0, vram_we | vram_re}, 64'd1);
        vram_ack   = 1'b1;
        vram_rdata = rdata;
        tick();
        vram_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_we", vram_we, 0);
        check("rst_re", vram_re, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_n_int", n_int, 1);
        check("rst_dout", cpu_dout, 8'h1F);
        check("rst_regs", regs, 0);
        check("rst_state", fsm_state, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_dout", cpu_dout, 8'h00);

        // Access with cpu_ce low is ignored
        cpu_ce = 1'b0; mode_ctrl = 1'b0; cpu_din = 8'h77; io_wr = 1'b1;
        tick(); tick();
        check("ce_low_we", vram_we, 0);
        check("ce_low_busy", busy, 0);
        io_wr = 1'b0; tick();
        cpu_ce = 1'b1; tick();

        // Write address 0x0000, data A5
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h40);
        check("setaddr_no_pf", vram_re, 0);
        check("setaddr_idle", busy, 0);
        cpu_write(1'b0, 8'hA5);
        check("wr1_we", vram_we, 1);
        check("wr1_addr", vram_addr, 14'h0000);
        check("wr1_wdata", vram_wdata, 8'hA5);
        check("wr1_busy", busy, 1);
        do_ack(8'h00);
        check("wr1_done", vram_we, 0);
        cpu_write(1'b0, 8'h11);
        check("wr2_addr", vram_addr, 14'h0001);
        check("wr2_wdata", vram_wdata, 8'h11);
        do_ack(8'h00);
        cpu_read_start(1'b0);
        check("rdbuf_from_write", cpu_dout, 8'h11);
        cpu_read_end();
        check("rd_end_pf", vram_re, 1);
        check("rd_end_pf_addr", vram_addr, 14'h0003);
        do_ack(8'h00);

        // Read setup at 0x0034 with prefetch
        cpu_write(1'b1, 8'h34);
        cpu_write(1'b1, 8'h00);
        check("pf_re", vram_re, 1);
        check("pf_addr", vram_addr, 14'h0034);
        do_ack(8'h5C);
        check("pf_done", vram_re, 0);
        cpu_read_start(1'b0);
        check("rd_data", cpu_dout, 8'h5C);
        cpu_read_end();
        check("pf2_re", vram_re, 1);
        check("pf2_addr", vram_addr, 14'h0035);
        do_ack(8'h77);

        // Register write R1=E0, frame interrupt, status read
        cpu_write(1'b1, 8'hE0);
        cpu_write(1'b1, 8'h81);
        check("r1_value", regs[15:8], 8'hE0);
        check("regs_all", regs, 64'h0000_0000_0000_E000);
        check("n_int_no_flag", n_int, 1);
        int_set = 1'b1; tick(); int_set = 1'b0;
        check("n_int_asserted", n_int, 0);
        cpu_read_start(1'b1);
        check("status_f", cpu_dout, 8'h9F);
        check("n_int_during_read", n_int, 0);
        cpu_read_end();
        check("n_int_after_read", n_int, 1);
        tick();
        check("status_cleared", cpu_dout, 8'h1F);

        // Collision set coinciding with status-read completion survives
        coll_set = 1'b1; tick(); coll_set = 1'b0;
        cpu_read_start(1'b1);
        check("status_c", cpu_dout, 8'h3F);
        io_rd = 1'b0; coll_set = 1'b1;
        tick();
        coll_set = 1'b0;
        cpu_read_start(1'b1);
        check("coll_wins_clear", cpu_dout, 8'h3F);
        cpu_read_end();
        fifth_num = 5'd7; fifth_set = 1'b1; tick(); fifth_set = 1'b0;
        cpu_read_start(1'b1);
        check("status_5s", cpu_dout, 8'h47);
        cpu_read_end();
        cpu_read_start(1'b1);
        check("status_5s_cleared", cpu_dout, 8'h1F);
        cpu_read_end();

        // Address wrap, pending slot and overrun with a stalled ack
        cpu_write(1'b1, 8'hFF);
        cpu_write(1'b1, 8'h7F);
        cpu_write(1'b0, 8'h01);
        check("wrap_wr_addr", vram_addr, 14'h3FFF);
        cpu_write(1'b0, 8'h02);
        check("pend_no_overrun", ovr_seen, 0);
        check("pend_busy", busy, 1);
        cpu_write(1'b0, 8'h03);
        check("overrun_pulse", ovr_seen, 1);
        check("overrun_one_cycle", overrun, 0);
        vram_ack = 1'b1; tick(); vram_ack = 1'b0;
        check("ack_to_idle", vram_we, 0);
        tick();
        check("pend_issue_we", vram_we, 1);
        check("pend_wrap_addr", vram_addr, 14'h0000);
        check("pend_wdata", vram_wdata, 8'h02);
        do_ack(8'h00);
        check("pend_drained", busy, 0);

        // Status read resets the byte latch
        cpu_write(1'b1, 8'h12);
        cpu_read_start(1'b1);
        cpu_read_end();
        cpu_write(1'b1, 8'h12);
        cpu_write(1'b1, 8'h40);
        check("latch_no_pf", vram_re, 0);
        check("latch_regs_same", regs, 64'h0000_0000_0000_E000);
        cpu_write(1'b0, 8'h99);
        check("latch_addr", vram_addr, 14'h0012);

        // Reset in the middle of a request
        do_ack(8'h00);
        cpu_write(1'b0, 8'h55);
        check("mid_req_we", vram_we, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", vram_we, 0);
        check("mid_rst_dout", cpu_dout, 8'h1F);
        tick();
        reset_n = 1'b1;
        vram_ack = 1'b1; tick(); vram_ack = 1'b0;
        tick();
        check("late_ack_busy", busy, 0);
        check("late_ack_we", vram_we, 0);
        check("late_ack_regs", regs, 0);
        check("late_ack_rdbuf", cpu_dout, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning VRAM address width.
REQ-002 SHALL have port clk, input, 1, system clock (cpuClock domain).
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpu_ce, input, 1, one-cycle CPU clock-edge strobe.
REQ-005 SHALL have port io_wr, input, 1, level-high CPU IO write to VDP (port BE/BF).
REQ-006 SHALL have port io_rd, input, 1, level-high CPU IO read from VDP.
REQ-007 SHALL have port mode_ctrl, input, 1: 1 selects control port BF, 0 selects data port BE.
REQ-008 SHALL have port cpu_din, input, 8, CPU write data.
REQ-009 SHALL have port cpu_dout, output, 8, read data: read buffer (data port) or status (control port).
REQ-010 SHALL have port vram_addr, output, ADDR_W, VRAM access address.
REQ-011 SHALL have port vram_wdata, output, 8, VRAM write data.
REQ-012 SHALL have port vram_we / vram_re, output, 1 each, VRAM requests, held until ack.
REQ-013 SHALL have port vram_ack, input, 1, one-cycle grant/completion from the video arbiter.
REQ-014 SHALL have port vram_rdata, input, 8, VRAM read data, valid with vram_ack.
REQ-015 SHALL have port regs, output, 64, VDP registers R0..R7 (R[n] at bits 8n+7:8n).
REQ-016 SHALL have port int_set / coll_set, input, 1 each, frame-interrupt and sprite-collision set pulses.
REQ-017 SHALL have port fifth_set, input, 1, fifth-sprite event pulse; fifth_num, input, 5, its sprite number.
REQ-018 SHALL have port n_int, output, 1, active-low interrupt = ~(F & R1[5]).
REQ-019 SHALL have port busy, output, 1, FSM not IDLE or pending slot full; overrun, output, 1, one-cycle drop pulse.

Function
REQ-020 SHALL act on an access once, in the first cpu_ce cycle where io_wr/io_rd is high after being low at the previous cpu_ce.
REQ-021 SHALL act on read-completion side effects in the first cpu_ce cycle where io_rd is low after being high.
REQ-022 Control write, latch flag clear: SHALL store cpu_din in first_byte and set the latch flag.
REQ-023 Control write, latch flag set, bit7=1: SHALL load R[cpu_din[2:0]] with first_byte and clear the latch flag.
REQ-024 Control write, latch flag set, bit7=0: SHALL load addr with {cpu_din[5:0], first_byte} and clear the latch flag; if bit6=0, SHALL also start a prefetch.
REQ-025 Any data-port access and any status read SHALL clear the latch flag.
REQ-026 Data write: SHALL load the read buffer with cpu_din and issue a VRAM write at addr, then increment addr.
REQ-027 Data read: SHALL present the read buffer on cpu_dout; at read completion it SHALL increment addr and then prefetch at the new addr.
REQ-028 FSM states: IDLE, WR (vram_we=1), PF (vram_re=1); WR/PF SHALL return to IDLE on vram_ack, and PF SHALL latch vram_rdata into the read buffer.
REQ-029 Requests SHALL hold vram_addr and vram_wdata stable until ack; latency from access to request SHALL be 1 clk.
REQ-030 A data access arriving while not IDLE SHALL enter a one-entry pending slot, issued on the IDLE cycle after ack.
REQ-031 If the pending slot is full, a further access SHALL be dropped with an overrun pulse.
REQ-032 addr SHALL wrap from 2^ADDR_W-1 to 0.
REQ-033 Status SHALL be {F, 5S, C, 5S ? fifth_num_latched : 5'b11111}.
REQ-034 F, C and 5S SHALL be sticky-set by int_set, coll_set and fifth_set (fifth_set latches fifth_num), and SHALL clear at status-read completion.
REQ-035 A set pulse in the same clk as a clear SHALL win.
REQ-036 Events with cpu_ce low SHALL be ignored except set pulses and vram_ack.

Reset
REQ-037 On reset_n low: regs=0, addr=0, read buffer=0, first_byte=0, latch flag=0, F=C=5S=0, FSM=IDLE, pending empty.
REQ-038 Outputs during reset: vram_we=vram_re=0, busy=0, overrun=0, n_int=1, cpu_dout=8'h1F.
REQ-039 Reset mid-request SHALL abandon the request with no further effect; a later vram_ack SHALL be ignored.

Structure
REQ-040 Status bit positions, FSM state encoding and port-select constants SHALL live in shared package vdp_pkg.
REQ-041 The status-flag logic SHALL be sub-module vdp_status (sticky set/clear, fifth-number latch).

Verification
REQ-042 Write ctrl 8'h00 then 8'h40, write data 8'hA5 -> one vram_we at 0x0000 with wdata A5; addr becomes 0x0001.
REQ-043 Write ctrl 8'h34 then 8'h00, ack with rdata 8'h5C -> prefetch at 0x0034; data read returns 5C; next prefetch at 0x0035.
REQ-044 Write ctrl 8'hE0 then 8'h81 -> regs[15:8]=E0; R1[5]=1; int_set pulse -> n_int=0; status read returns 8'h9F; n_int=1 after read completes.
REQ-045 Write ctrl 8'hFF then 8'h7F, data write, stall ack -> addr wraps to 0x0000; second write is pending; third write gives an overrun pulse.
REQ-046 Write single ctrl byte 8'h12, then status read, then ctrl 8'h12, 8'h40 -> latch flag reset by status read; final addr=0x0012 with no register write.
REQ-047 coll_set in the same clk as status-read completion -> C remains 1.
